adder32_arbiter: RTL



---
 rtl/adder32_arb_pkg.sv | 22 ++
 rtl/adder32_arbiter_if.sv | 43 ++++
 rtl/adder32_arbiter_rr_arbiter.sv | 34 +++
 rtl/adder32_arbiter.sv | 104 ++++++++++
 4 files changed

// File: rtl/adder32_arb_pkg.sv
// Shared types and helpers for the adder32_arbiter block.
// Optional feature macro: ADDER32_ARB_CARRY_EN (carry-out on the response).
package adder32_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 32;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Requester index k places after ptr, wrapping modulo n.
    function automatic int unsigned wrap_idx(
        input int unsigned ptr,
        input int unsigned k,
        input int unsigned n
    );
        return (ptr + k) % n;
    endfunction

endpackage

// File: rtl/adder32_arbiter_if.sv
// Request/response bundle between clients and adder32_arbiter.
// master = client side, slave = arbiter side; rsp_carry needs ADDER32_ARB_CARRY_EN.
interface adder32_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 2
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W-1:0]         rsp_data;
    logic [ID_W-1:0]           rsp_id;
`ifdef ADDER32_ARB_CARRY_EN
    logic                      rsp_carry;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id,
        input  rsp_carry
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id,
        output rsp_carry
    );
`else
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
`endif

endinterface

// File: rtl/adder32_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or after ptr.
// Ports: req, ptr, en in; one-hot gnt and encoded idx out.
module adder32_arbiter_rr_arbiter
    import adder32_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] j;
    logic          found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        j     = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = IW'(wrap_idx(32'(ptr), k, N));
            if (en && !found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/adder32_arbiter.sv
// Round-robin sharing of one wrap-around adder between NUM_REQ clients.
// Ports: clk, rst (sync, high), bus (slave); carry via ADDER32_ARB_CARRY_EN.
module adder32_arbiter
    import adder32_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ID_W    = 2
) (
    input logic              clk,
    input logic              rst,
    adder32_arbiter_if.slave bus
);

    state_t              state_q;
    state_t              state_d;
    logic [ID_W-1:0]     ptr_q;
    logic [DATA_W-1:0]   data_q;
    logic [ID_W-1:0]     id_q;

    logic                can_accept;
    logic                fire;
    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     gidx;
    logic [DATA_W-1:0]   a_sel;
    logic [DATA_W-1:0]   b_sel;

    // Slot frees up either when empty or when the held response retires now.
    assign can_accept = (state_q == IDLE) || bus.rsp_ready;

    adder32_arbiter_rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .req (bus.req_valid),
        .ptr (ptr_q),
        .en  (can_accept && !rst),
        .gnt (gnt),
        .idx (gidx)
    );

    // gnt is only ever set on a valid requester.
    assign fire  = |gnt;
    assign a_sel = bus.req_a[gidx*DATA_W +: DATA_W];
    assign b_sel = bus.req_b[gidx*DATA_W +: DATA_W];

`ifdef ADDER32_ARB_CARRY_EN
    logic [DATA_W:0] sum;
    logic            carry_q;

    assign sum = {1'b0, a_sel} + {1'b0, b_sel};
`else
    logic [DATA_W-1:0] sum;

    assign sum = a_sel + b_sel;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (fire) state_d = HOLD;
            HOLD: if (bus.rsp_ready && !fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = gnt;
        bus.rsp_valid = (state_q == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            data_q  <= '0;
            id_q    <= '0;
`ifdef ADDER32_ARB_CARRY_EN
            carry_q <= 1'b0;
`endif
        end else if (fire) begin
            ptr_q   <= ID_W'(wrap_idx(32'(gidx), 1, NUM_REQ));
            data_q  <= sum[DATA_W-1:0];
            id_q    <= gidx;
`ifdef ADDER32_ARB_CARRY_EN
            carry_q <= sum[DATA_W];
`endif
        end
    end

    assign bus.rsp_data  = data_q;
    assign bus.rsp_id    = id_q;
`ifdef ADDER32_ARB_CARRY_EN
    assign bus.rsp_carry = carry_q;
`endif

endmodule
